// File: rtl/ysyx_25030093_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter.
package ysyx_25030093_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25030093_rr_pick.sv
// Two-way round-robin winner selection; combinational only.
module ysyx_25030093_rr_pick
    import ysyx_25030093_arb_pkg::*;
(
    input  logic ifu_valid,
    input  logic lsu_valid,
    input  logic rr_last,
    output logic winner,
    output logic any_valid
);

    always_comb begin
        any_valid = ifu_valid | lsu_valid;
        winner    = GRANT_IFU;
        if (ifu_valid && lsu_valid) begin
            winner = ~rr_last;
        end else if (lsu_valid) begin
            winner = GRANT_LSU;
        end
    end

endmodule

// File: rtl/ysyx_25030093_mem_arbiter.sv
// Shares one memory port between IFU and LSU: one transaction at a time,
// round-robin on ties, with a timeout that turns a hung slave into an error.
module ysyx_25030093_mem_arbiter
    import ysyx_25030093_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    input  logic                ifu_resp_ready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    input  logic                lsu_resp_ready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    output logic                mem_resp_ready,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_resp_err,

    output logic                grant,
    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TLIM   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit          TO_EN  = (TIMEOUT != 0);

    arb_state_e          state_q, state_d;
    logic                grant_q, grant_d;
    logic                rr_last_q, rr_last_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [MASK_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                winner;
    logic                any_valid;
    logic                timed_out;
    logic                resp_taken;

    ysyx_25030093_rr_pick u_rr_pick (
        .ifu_valid (ifu_req_valid),
        .lsu_valid (lsu_req_valid),
        .rr_last   (rr_last_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Once past the limit (handshake won at expiry), the next idle cycle times out.
    assign timed_out  = TO_EN && (timer_q >= TW'(TLIM));
    assign resp_taken = (grant_q == GRANT_LSU) ? lsu_resp_ready : ifu_resp_ready;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_last_d     = rr_last_q;
        timer_d       = timer_q;
        addr_d        = addr_q;
        wen_d         = wen_q;
        wdata_d       = wdata_q;
        wmask_d       = wmask_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;

        case (state_q)
            IDLE: begin
                ifu_req_ready = any_valid && (winner == GRANT_IFU);
                lsu_req_ready = any_valid && (winner == GRANT_LSU);
                if (any_valid) begin
                    grant_d = winner;
                    timer_d = '0;
                    state_d = ISSUE;
                    if (winner == GRANT_LSU) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            ISSUE: begin
                timer_d = timer_q + TW'(1);
                if (mem_req_ready) begin
                    state_d = WAIT;
                end else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            WAIT: begin
                timer_d = timer_q + TW'(1);
                if (mem_resp_valid) begin
                    rdata_d = mem_rdata;
                    err_d   = mem_resp_err;
                    state_d = RESP;
                end else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_taken) begin
                    rr_last_d = grant_q;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= GRANT_IFU;
            rr_last_q <= GRANT_LSU;
            timer_q   <= '0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_last_q <= rr_last_d;
            timer_q   <= timer_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Handshake strobes are pure decodes of the state register.
    assign mem_req_valid  = (state_q == ISSUE);
    assign mem_resp_ready = (state_q == WAIT);
    assign ifu_resp_valid = (state_q == RESP) && (grant_q == GRANT_IFU);
    assign lsu_resp_valid = (state_q == RESP) && (grant_q == GRANT_LSU);
    assign busy           = (state_q != IDLE);
    assign grant          = grant_q;

    assign mem_addr     = addr_q;
    assign mem_wen      = wen_q;
    assign mem_wdata    = wdata_q;
    assign mem_wmask    = wmask_q;
    assign ifu_rdata    = rdata_q;
    assign ifu_resp_err = err_q;
    assign lsu_rdata    = rdata_q;
    assign lsu_resp_err = err_q;

endmodule

// File: doc/ysyx_25030093_mem_arbiter.md
Name: ysyx_25030093_mem_arbiter

Overview:
- Shares one memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU) of the ysyx_25030093 core.
- Accepts one request at a time and arbitrates ties round-robin. Drives a valid/ready request and response handshake to memory, then returns the response to the granted master.
- A timeout counter turns a hung slave into an error response.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
TIMEOUT, 16, cycles allowed in ISSUE+WAIT before an error response; 0 disables the timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted
ifu_addr  in  ADDR_W  IFU read address
ifu_resp_valid  out  1  IFU response valid
ifu_resp_ready  in  1  IFU takes response
ifu_rdata  out  DATA_W  IFU read data
ifu_resp_err  out  1  IFU response error
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_addr  in  ADDR_W  LSU address
lsu_wen  in  1  1 = write
lsu_wdata  in  DATA_W  write data
lsu_wmask  in  DATA_W/8  byte-enable mask
lsu_resp_valid  out  1  LSU response valid
lsu_resp_ready  in  1  LSU takes response
lsu_rdata  out  DATA_W  LSU read data
lsu_resp_err  out  1  LSU response error
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  latched address
mem_wen  out  1  latched write enable
mem_wdata  out  DATA_W  latched write data
mem_wmask  out  DATA_W/8  latched byte mask
mem_resp_valid  in  1  memory response
mem_resp_ready  out  1  arbiter accepts response
mem_rdata  in  DATA_W  memory read data
mem_resp_err  in  1  memory error
grant  out  1  0 = IFU, 1 = LSU (current owner)
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): the following are cleared.
  - State goes to IDLE.
  - All registered outputs go to 0.
  - grant=0 and rr_last=1 (so IFU wins the first tie).
  - Timer = 0.
  - An in-flight transaction is dropped without a response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner selection:
    - Only one master has valid: that master wins.
    - Both valid: the master opposite rr_last wins.
  - The winner's req_ready is driven combinationally high in IDLE. The loser's req_ready is 0.
  - On handshake:
    - Latch addr, wen, wdata, wmask. For IFU these are wen=0, wdata=0, wmask=0.
    - Set grant to the winner.
    - Go to ISSUE with timer=0.
  - No valid: stay in IDLE.
- ISSUE:
  - mem_req_valid=1 with the latched fields held stable.
  - mem_req_ready=1: go to WAIT.
- WAIT:
  - mem_resp_ready=1.
  - mem_resp_valid=1: latch rdata and err, go to RESP.
- Timeout (TIMEOUT>0):
  - The timer increments each cycle in ISSUE and WAIT.
  - Timer == TIMEOUT-1 with no handshake that cycle: go to RESP with err=1 and rdata=0.
  - A handshake in the same cycle as expiry wins over the timeout.
- RESP:
  - The granted master's resp_valid=1, with rdata/err from registers. The other master's resp_valid=0.
  - On resp_ready: set rr_last=grant and go to IDLE.
- Outside WAIT: mem_resp_ready=0. A stale response from a timed-out slave is not consumed.
- Minimum latency with zero-wait memory: accept at cycle 0, mem request at cycle 1, response latched by cycle 2, resp_valid at cycle 3. Throughput is one transaction per 4 cycles.
- Masters may deassert req_valid or change fields after their handshake; the latched copy is used.
- A new request raised during a non-IDLE state waits (req_ready=0).
- busy=1 in all states except IDLE.

Decomposition:
- Package ysyx_25030093_arb_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - GRANT_IFU=1'b0 and GRANT_LSU=1'b1.
- One sub-module, ysyx_25030093_rr_pick:
  - inputs: two valids and rr_last;
  - outputs: winner and any_valid;
  - purely combinational.

Test Plan:
- IFU only, addr 0x8000_0000; memory ready immediately, rdata 0x0000_0413 one cycle later.
  - Required: ifu_req_ready at cycle 0, mem_req_valid at cycle 1, ifu_resp_valid at cycle 3 with rdata 0x0000_0413 and err=0.
  - Required: lsu_resp_valid stays 0.
- LSU write addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 0xF; memory stalls mem_req_ready for 3 cycles.
  - Required: mem_addr, mem_wdata and mem_wmask are stable throughout; mem_wen=1.
  - Required: lsu_resp_valid is asserted once, after the memory responds.
- IFU and LSU both valid at reset release, back-to-back.
  - Required grant order: IFU, LSU, IFU, LSU.
  - Required: each master's resp_valid appears only in its own transaction.
- TIMEOUT=16; memory never asserts mem_resp_valid.
  - Required: 16 cycles after entry to ISSUE, RESP with err=1 and rdata=0.
  - Required: mem_resp_ready=0 after leaving WAIT.
- Master holds resp_ready=0 for 5 cycles in RESP.
  - Required: resp_valid, rdata and err are stable for all 5 cycles; no new request is accepted.
- rst asserted low during WAIT.
  - Required: all outputs go to 0 immediately, without a clock edge.
  - Required: after release, IFU wins a tie.
